// File: rtl/nes_fetch_queue.sv
// Variable-length 6502 fetch unit: reads one byte per request, assembles 1..3 byte
// instructions and buffers them in a small FIFO for the decoder.
module nes_fetch_queue #(
  parameter int unsigned                 MEM_ADDR_SIZE  = 16,
  parameter logic [MEM_ADDR_SIZE-1:0]    BOOT_ADDR      = 16'h0000,
  parameter int unsigned                 MAX_INSTR_SIZE = 3,
  parameter int unsigned                 QUEUE_DEPTH    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        mem_rd_o,
  output logic [MEM_ADDR_SIZE-1:0]    mem_addr_o,
  input  logic [7:0]                  mem_rdata_i,
  input  logic                        mem_rvalid_i,
  input  logic                        redirect_i,
  input  logic [MEM_ADDR_SIZE-1:0]    redirect_pc_i,
  output logic                        instr_valid_o,
  input  logic                        instr_ready_i,
  output logic [MAX_INSTR_SIZE*8-1:0] instr_o,
  output logic [1:0]                  instr_len_o,
  output logic [MEM_ADDR_SIZE-1:0]    instr_pc_o
);

  localparam int unsigned IW      = MAX_INSTR_SIZE * 8;
  localparam int unsigned PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned ENTRY_W = MEM_ADDR_SIZE + 2 + IW;
  localparam logic [7:0]  NOP     = 8'hEA;

  typedef enum logic [1:0] {
    FETCH_OPCODE,
    FETCH_ABS_B0,
    FETCH_ABS_B1,
    FETCH_INSTR_READY
  } fetch_state_t;

  function automatic logic [1:0] instr_len(input logic [7:0] op);
    logic [2:0] bbb;
    bbb       = op[4:2];
    instr_len = 2'd2;
    case (op[1:0])
      2'b01: if (bbb inside {3'b011, 3'b110, 3'b111}) instr_len = 2'd3;
      2'b10: begin
        if (bbb inside {3'b010, 3'b100, 3'b110})  instr_len = 2'd1;
        else if (bbb inside {3'b011, 3'b111})     instr_len = 2'd3;
      end
      2'b00: begin
        if (bbb == 3'b000) begin
          if (op == 8'h20)                         instr_len = 2'd3;
          else if (op inside {8'h00, 8'h40, 8'h60}) instr_len = 2'd1;
        end else if (bbb inside {3'b010, 3'b110})  instr_len = 2'd1;
        else if (bbb inside {3'b011, 3'b111})      instr_len = 2'd3;
      end
      default: instr_len = 2'd1;
    endcase
  endfunction

  fetch_state_t             state_q, state_d;
  logic [MEM_ADDR_SIZE-1:0] pc_q, pc_d, ipc_q, ipc_d;
  logic                     pend_q, pend_d, drop_q, drop_d;
  logic [7:0]               op_q, op_d, b0_q, b0_d, b1_q, b1_d;
  logic [1:0]               len_q, len_d;

  logic [ENTRY_W-1:0]       q_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         count_q;
  logic [ENTRY_W-1:0]       q_wdata;

  logic take, complete, push, issue, full, empty, pop;

  assign full  = (count_q == CNT_W'(QUEUE_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && instr_ready_i && !redirect_i;
  assign take  = pend_q && mem_rvalid_i;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    drop_d   = drop_q;
    op_d     = op_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    ipc_d    = ipc_q;
    len_d    = len_q;
    complete = 1'b0;
    push     = 1'b0;
    issue    = 1'b0;
    if (redirect_i) begin
      state_d = FETCH_OPCODE;
      pc_d    = redirect_pc_i;
      // A read still in flight must be swallowed when it finally returns.
      pend_d  = pend_q && !mem_rvalid_i;
      drop_d  = pend_q && !mem_rvalid_i;
    end else begin
      if (take) begin
        pend_d = 1'b0;
        drop_d = 1'b0;
        if (!drop_q) begin
          unique case (state_q)
            FETCH_OPCODE: begin
              op_d  = mem_rdata_i;
              b0_d  = '0;
              b1_d  = '0;
              ipc_d = pc_q - MEM_ADDR_SIZE'(1);
              len_d = instr_len(mem_rdata_i);
              if (len_d == 2'd1) complete = 1'b1;
              else               state_d  = FETCH_ABS_B0;
            end
            FETCH_ABS_B0: begin
              b0_d = mem_rdata_i;
              if (len_q == 2'd2) complete = 1'b1;
              else               state_d  = FETCH_ABS_B1;
            end
            FETCH_ABS_B1: begin
              b1_d     = mem_rdata_i;
              complete = 1'b1;
            end
            default: ;
          endcase
        end
      end
      if (complete || state_q == FETCH_INSTR_READY) begin
        if (!full || pop) begin
          push    = 1'b1;
          state_d = FETCH_OPCODE;
        end else begin
          state_d = FETCH_INSTR_READY;
        end
      end
      // Back-to-back issue is allowed in the cycle the previous byte returns.
      if (state_q != FETCH_INSTR_READY && state_d != FETCH_INSTR_READY &&
          (!pend_q || (take && !drop_q))) begin
        issue  = 1'b1;
        pend_d = 1'b1;
        pc_d   = pc_q + MEM_ADDR_SIZE'(1);
      end
    end
  end

  assign q_wdata    = {ipc_d, len_d, IW'({b1_d, b0_d, op_d})};
  assign mem_rd_o   = issue && !rst;
  assign mem_addr_o = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_OPCODE;
      pc_q    <= BOOT_ADDR;
      pend_q  <= 1'b0;
      drop_q  <= 1'b0;
      op_q    <= NOP;
      b0_q    <= '0;
      b1_q    <= '0;
      ipc_q   <= '0;
      len_q   <= 2'd1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      op_q    <= op_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      ipc_q   <= ipc_d;
      len_q   <= len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q] <= q_wdata;
  end

  always_comb begin
    instr_valid_o = !empty;
    instr_o       = IW'(NOP);
    instr_len_o   = 2'd1;
    instr_pc_o    = '0;
    if (!empty) {instr_pc_o, instr_len_o, instr_o} = q_mem[rd_ptr_q];
  end

endmodule

// File: tb/tb_nes_fetch_queue.sv
// Randomized scoreboard bench for nes_fetch_queue with a latency-variable memory model
// and a byte-stream reference model of the expected instruction sequence.
module tb_nes_fetch_queue;
  localparam int unsigned DEPTH = 2;
  localparam logic [15:0] BOOT  = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd, mem_rvalid = 1'b0, redirect = 1'b0, instr_valid, instr_ready = 1'b0;
  logic [15:0] mem_addr, redirect_pc = '0, instr_pc;
  logic [7:0]  mem_rdata = '0;
  logic [23:0] instr;
  logic [1:0]  instr_len;

  nes_fetch_queue #(
    .MEM_ADDR_SIZE (16),
    .BOOT_ADDR     (BOOT),
    .MAX_INSTR_SIZE(3),
    .QUEUE_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_rd_o     (mem_rd),
    .mem_addr_o   (mem_addr),
    .mem_rdata_i  (mem_rdata),
    .mem_rvalid_i (mem_rvalid),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready),
    .instr_o      (instr),
    .instr_len_o  (instr_len),
    .instr_pc_o   (instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [1:0]  len;
    logic [23:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  memb [0:65535];
  int          checks = 0, errors = 0;
  logic [15:0] model_pc = BOOT, exp_req_addr = BOOT;

  // memory model: one outstanding read, tagged with the redirect epoch it was issued in
  bit          m_pend = 1'b0;
  int          m_cnt = 0, m_gen = 0, cur_gen = 0;
  logic [15:0] m_addr = '0;
  bit          req_seen = 1'b0, stale_now = 1'b0, must_req = 1'b0, prev_flush = 1'b0;
  logic [15:0] req_addr_s = '0;
  int          req_count = 0, lat_mode = 1, ready_pct = 100;
  bit          next_rst = 1'b0, next_redirect = 1'b0, last_valid = 1'b0;
  logic [15:0] next_pc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_len(input logic [7:0] op);
    int a, b, c;
    a = int'(op[7:5]);
    b = int'(op[4:2]);
    c = int'(op[1:0]);
    if (c == 3) return 1;
    if (c == 1) return (b == 3 || b == 6 || b == 7) ? 3 : 2;
    if (c == 2) begin
      if (b == 2 || b == 4 || b == 6) return 1;
      return (b == 3 || b == 7) ? 3 : 2;
    end
    if (b == 0) begin
      if (op == 8'h20) return 3;
      return (a == 0 || a == 2 || a == 3) ? 1 : 2;
    end
    if (b == 2 || b == 6) return 1;
    return (b == 3 || b == 7) ? 3 : 2;
  endfunction

  task automatic model_fill(input int n);
    exp_t        e;
    logic [15:0] p1, p2;
    int          l;
    for (int i = 0; i < n; i++) begin
      p1      = model_pc + 16'd1;
      p2      = model_pc + 16'd2;
      l       = ref_len(memb[model_pc]);
      e.pc    = model_pc;
      e.len   = 2'(l);
      e.instr = {(l == 3) ? memb[p2] : 8'h00, (l >= 2) ? memb[p1] : 8'h00, memb[model_pc]};
      sb.push_back(e);
      model_pc = model_pc + 16'(l);
    end
  endtask

  // Monitor: protocol checks and scoreboard pops, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      req_seen   = 1'b0;
      must_req   = 1'b1;
      prev_flush = 1'b1;
    end else begin
      if (must_req && !redirect) check("req_after_restart", 32'(mem_rd), 32'd1);
      if (redirect)  check("no_req_on_redirect", 32'(mem_rd), 32'd0);
      if (stale_now) check("no_req_on_stale", 32'(mem_rd), 32'd0);
      if (mem_rd) begin
        check("single_outstanding", 32'(m_pend), 32'd0);
        check("req_addr", 32'(mem_addr), 32'(exp_req_addr));
        exp_req_addr = exp_req_addr + 16'd1;
        req_count++;
      end
      req_seen   = mem_rd;
      req_addr_s = mem_addr;
      if (prev_flush) check("valid_after_flush", 32'(instr_valid), 32'd0);
      if (!instr_valid) begin
        check("empty_instr", 32'(instr), 32'h0000EA);
        check("empty_len", 32'(instr_len), 32'd1);
        check("empty_pc", 32'(instr_pc), 32'd0);
      end else if (instr_ready && !redirect) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("instr", 32'(instr), 32'(e.instr));
          check("len", 32'(instr_len), 32'(e.len));
          check("pc", 32'(instr_pc), 32'(e.pc));
        end
      end
      must_req   = redirect ? !m_pend : stale_now;
      prev_flush = redirect;
    end
    last_valid = instr_valid;
  end

  // One clock of stimulus: memory model, control, and reference-stream bookkeeping.
  task automatic step();
    @(posedge clk);
    #1;
    if (req_seen) begin
      m_pend = 1'b1;
      m_addr = req_addr_s;
      m_gen  = cur_gen;
      m_cnt  = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
    end
    rst      = next_rst;
    redirect = next_redirect && !next_rst;
    if (rst) begin
      m_pend       = 1'b0;
      cur_gen++;
      sb.delete();
      model_pc     = BOOT;
      exp_req_addr = BOOT;
      req_count    = 0;
      model_fill(32);
    end else if (redirect) begin
      redirect_pc  = next_pc;
      cur_gen++;
      sb.delete();
      model_pc     = next_pc;
      exp_req_addr = next_pc;
      model_fill(32);
    end
    next_rst      = 1'b0;
    next_redirect = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = 8'($urandom);
    stale_now     = 1'b0;
    if (m_pend) begin
      m_cnt--;
      if (m_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memb[m_addr];
        stale_now  = (m_gen != cur_gen);
        m_pend     = 1'b0;
      end
    end
    instr_ready = ($urandom_range(0, 99) < ready_pct);
    if (sb.size() < 16) model_fill(16);
  endtask

  task automatic restart();
    next_rst = 1'b1;
    step();
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 65536; i++) memb[i] = 8'($urandom);

    // single-byte NOP at boot
    memb[0] = 8'hEA;
    lat_mode = 1; ready_pct = 100;
    restart();
    repeat (10) step();

    // absolute 3-byte instruction
    memb[0] = 8'hAD; memb[1] = 8'h34; memb[2] = 8'h12;
    restart();
    repeat (12) step();

    // mixed-length stream
    memb[0] = 8'hA9; memb[1] = 8'h05; memb[2] = 8'h20;
    memb[3] = 8'h00; memb[4] = 8'h80; memb[5] = 8'h60;
    restart();
    repeat (15) step();

    // decoder stall: queue fills plus one held instruction, then fetch stops
    for (int i = 0; i < 64; i++) memb[i] = 8'hEA;
    ready_pct = 0;
    restart();
    repeat (30) step();
    @(negedge clk);
    #1;
    check("stall_req_count", 32'(req_count), 32'(DEPTH + 1));
    check("stall_valid", 32'(instr_valid), 32'd1);
    check("stall_no_req", 32'(mem_rd), 32'd0);
    ready_pct = 100;
    repeat (12) step();

    // slow memory, redirect while a read is in flight
    for (int i = 0; i < 64; i++) memb[i] = 8'($urandom);
    lat_mode = 3;
    restart();
    step();
    next_redirect = 1'b1; next_pc = 16'h8000;
    step();
    repeat (25) step();

    // redirect coinciding with returning data and a decoder pop
    lat_mode = 1;
    restart();
    repeat (6) step();
    guard = 0;
    while (!(last_valid && req_seen) && guard < 50) begin
      step();
      guard++;
    end
    next_redirect = 1'b1; next_pc = 16'(16'h4000 + $urandom_range(0, 255));
    step();
    repeat (15) step();

    // reset while the operand byte is outstanding
    memb[0] = 8'hAD; memb[1] = 8'h34; memb[2] = 8'h12;
    lat_mode = 3;
    restart();
    repeat (5) step();
    restart();
    repeat (20) step();

    // randomized soak
    lat_mode = 0; ready_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) < 30) begin
        next_redirect = 1'b1;
        next_pc       = 16'($urandom_range(0, 65535));
      end
      if ($urandom_range(0, 999) < 3) next_rst = 1'b1;
      step();
    end
    ready_pct = 100;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
